// File: rtl/hdmi_stream_pkg.sv
// Shared definitions for the HDMI capture-to-DDR path: writer FSM encoding,
// fixed AXI4 field values and the frame_height_width field layout.
package hdmi_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // frame_height_width = {4'b0, H[11:0], 4'b0, W[11:0]}
  localparam int FHW_W_LSB = 0;
  localparam int FHW_W_MSB = 11;
  localparam int FHW_H_LSB = 16;
  localparam int FHW_H_MSB = 27;

endpackage

// File: rtl/hdmi_frame_axi_writer_if.sv
// AXI4 write-only bus (AW/W/B) between the frame writer and the DDR interconnect.
interface hdmi_frame_axi_writer_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/hdmi_frame_axi_writer.sv
// Turns the capture FIFO's burst descriptors + pixel words into AXI4 INCR write
// bursts over a linear frame buffer. Optional double buffering: HDMI_FRAME_PINGPONG_EN.
module hdmi_frame_axi_writer
  import hdmi_stream_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
`ifdef HDMI_FRAME_PINGPONG_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR_B = 32'h0080_0000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] frame_height_width,

  input  logic        s_burst_valid,
  output logic        s_burst_ready,
  input  logic [7:0]  s_burst_len,
  input  logic        s_addr_reset,

  input  logic        s_data_valid,
  output logic        s_data_ready,
  input  logic [31:0] s_data,
  input  logic        s_data_last,

  hdmi_frame_axi_writer_if.master m_axi,

  output logic        frame_done,
  output logic        wr_error
);

  wr_state_e             state;
  logic [23:0]           offset;
  logic [23:0]           frame_words;
  logic [7:0]            len_q;
  logic [7:0]            beat;
  logic                  pending_reset;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] base_addr;

  logic [11:0] frame_h;
  logic [11:0] frame_w;
  logic        unused_fhw;
  logic        offset_clear;
  logic        w_last;
  logic        w_beat;
  logic [23:0] start_offset;
  logic [24:0] next_offset;

  assign frame_h    = frame_height_width[FHW_H_MSB:FHW_H_LSB];
  assign frame_w    = frame_height_width[FHW_W_MSB:FHW_W_LSB];
  assign unused_fhw = &{1'b0, frame_height_width[31:28], frame_height_width[15:12]};

  assign offset_clear = s_addr_reset || !enable;
  assign w_last       = (state == ST_W) && (beat == len_q);
  assign w_beat       = (state == ST_W) && s_data_valid && m_axi.wready;
  assign start_offset = offset_clear ? 24'd0 : offset;
  // 25 bits so a burst straddling the end of a near-maximal frame still compares correctly.
  assign next_offset  = {1'b0, offset} + {17'd0, len_q} + 25'd1;

`ifdef HDMI_FRAME_PINGPONG_EN
  logic buf_sel;
  assign base_addr = buf_sel ? BASE_ADDR_B : BASE_ADDR;
`else
  assign base_addr = BASE_ADDR;
`endif

  assign s_burst_ready   = (state == ST_IDLE) && enable;

  assign m_axi.awaddr    = awaddr_q;
  assign m_axi.awlen     = len_q;
  assign m_axi.awsize    = SIZE_4B;
  assign m_axi.awburst   = BURST_INCR;
  assign m_axi.awvalid   = (state == ST_AW);

  // NOTE: the W channel is a combinational pass-through; registering it would need a
  // skid buffer to keep the source and the interconnect ready/valid decoupled.
  assign m_axi.wdata     = s_data;
  assign m_axi.wstrb     = 4'hf;
  assign m_axi.wlast     = w_last;
  assign m_axi.wvalid    = (state == ST_W) && s_data_valid;
  assign s_data_ready    = (state == ST_W) && m_axi.wready;

  assign m_axi.bready    = (state == ST_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      offset        <= 24'd0;
      frame_words   <= 24'd0;
      len_q         <= 8'd0;
      beat          <= 8'd0;
      pending_reset <= 1'b0;
      awaddr_q      <= BASE_ADDR;
      frame_done    <= 1'b0;
      wr_error      <= 1'b0;
`ifdef HDMI_FRAME_PINGPONG_EN
      buf_sel       <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Multiplier result is only consumed at B completion, so it is refreshed here.
          frame_words <= {12'd0, frame_h} * {12'd0, frame_w};
          if (offset_clear) offset <= 24'd0;
          if (s_burst_valid && s_burst_ready) begin
            len_q    <= s_burst_len;
            awaddr_q <= base_addr + ADDR_WIDTH'({start_offset, 2'b00});
            beat     <= 8'd0;
            state    <= ST_AW;
          end
        end

        ST_AW: begin
          if (offset_clear) pending_reset <= 1'b1;
          if (m_axi.awready) state <= ST_W;
        end

        ST_W: begin
          if (offset_clear) pending_reset <= 1'b1;
          if (w_beat) begin
            if (s_data_last != w_last) wr_error <= 1'b1;
            if (w_last) state <= ST_B;
            else        beat  <= beat + 8'd1;
          end
        end

        ST_B: begin
          if (m_axi.bvalid) begin
            if (m_axi.bresp != RESP_OKAY) wr_error <= 1'b1;
            // A requested restart beats the wrap and never counts as a finished frame.
            if (pending_reset || offset_clear) begin
              offset <= 24'd0;
            end else if (frame_words != 24'd0 && next_offset >= {1'b0, frame_words}) begin
              offset     <= 24'd0;
              frame_done <= 1'b1;
`ifdef HDMI_FRAME_PINGPONG_EN
              buf_sel    <= ~buf_sel;
`endif
            end else begin
              offset <= next_offset[23:0];
            end
            pending_reset <= 1'b0;
            state         <= ST_IDLE;
          end else if (offset_clear) begin
            pending_reset <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_frame_axi_writer.sv
// Directed bench for hdmi_frame_axi_writer: a table of bursts with hand-computed
// addresses/flags plus short sequences for reset, enable drop and idle offset restart.
module tb_hdmi_frame_axi_writer;

`ifdef HDMI_FRAME_PINGPONG_EN
  localparam logic [31:0] B1 = 32'h0080_0000;
`else
  localparam logic [31:0] B1 = 32'h0000_0000;
`endif
  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] frame_height_width;
  logic        s_burst_valid;
  logic        s_burst_ready;
  logic [7:0]  s_burst_len;
  logic        s_addr_reset;
  logic        s_data_valid;
  logic        s_data_ready;
  logic [31:0] s_data;
  logic        s_data_last;
  logic        frame_done;
  logic        wr_error;

  int checks = 0;
  int errors = 0;

  hdmi_frame_axi_writer_if axi ();

  hdmi_frame_axi_writer dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .frame_height_width (frame_height_width),
    .s_burst_valid      (s_burst_valid),
    .s_burst_ready      (s_burst_ready),
    .s_burst_len        (s_burst_len),
    .s_addr_reset       (s_addr_reset),
    .s_data_valid       (s_data_valid),
    .s_data_ready       (s_data_ready),
    .s_data             (s_data),
    .s_data_last        (s_data_last),
    .m_axi              (axi.master),
    .frame_done         (frame_done),
    .wr_error           (wr_error)
  );

  always #5 clk = ~clk;

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // mode: 0 plain, 1 s_addr_reset pulse during W, 2 enable dropped during W
  typedef struct {
    bit          do_rst;
    logic [11:0] h;
    logic [11:0] w;
    logic [7:0]  len;
    int          bad_last;
    logic [1:0]  resp;
    bit          stall;
    int          mode;
    logic [31:0] exp_addr;
    bit          exp_done;
    bit          exp_err;
  } burst_vec_t;

  burst_vec_t vecs[21];
  burst_vec_t hv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; s_burst_valid = 1'b0; s_burst_len = 8'd0;
    s_addr_reset = 1'b0; s_data_valid = 1'b0; s_data = 32'd0; s_data_last = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_burst(input string tag, input burst_vec_t v);
    int          n;
    int          beat;
    int          data_err;
    int          last_err;
    int          stab_err;
    bit          seen;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] word;
    logic [7:0]  b8;

    frame_height_width = {4'b0, v.h, 4'b0, v.w};
    enable        = 1'b1;
    s_burst_valid = 1'b1;
    s_burst_len   = v.len;
    #1;
    n = 0;
    while (!s_burst_ready && n < TIMEOUT) begin
      @(negedge clk); #1; n++;
    end
    check({tag, " desc_timeout"}, n >= TIMEOUT, 0);
    @(negedge clk);
    s_burst_valid = 1'b0;
    #1;
    check({tag, " awvalid_latency"}, axi.awvalid, 1);

    n = 0; seen = 0; stab_err = 0; a0 = 32'd0; l0 = 8'd0;
    while (n < TIMEOUT) begin
      axi.awready = v.stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      #1;
      if (axi.awvalid) begin
        if (!seen) begin
          a0 = axi.awaddr; l0 = axi.awlen; seen = 1;
        end else if (axi.awaddr !== a0 || axi.awlen !== l0) begin
          stab_err++;
        end
      end
      if (axi.awvalid && axi.awready) break;
      @(negedge clk); n++;
    end
    @(negedge clk);
    axi.awready = 1'b0;
    check({tag, " awaddr"}, a0, v.exp_addr);
    check({tag, " awlen"}, {24'd0, l0}, {24'd0, v.len});
    check({tag, " aw_stable_errs"}, stab_err, 0);

    beat = 0; n = 0; data_err = 0; last_err = 0;
    while (beat <= int'(v.len) && n < TIMEOUT) begin
      b8   = 8'(beat);
      word = {8'hff, 8'(n), b8, ~b8};
      s_data       = word;
      s_data_last  = (v.bad_last >= 0) ? (beat == v.bad_last) : (beat == int'(v.len));
      s_data_valid = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      axi.wready   = v.stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_addr_reset = (v.mode == 1) && (beat == 2);
      if (v.mode == 2 && beat == 2) enable = 1'b0;
      #1;
      if (axi.wvalid !== s_data_valid || s_data_ready !== axi.wready) data_err++;
      if (s_data_valid && axi.wready) begin
        if (axi.wdata !== word) data_err++;
        if (axi.wlast !== (beat == int'(v.len))) last_err++;
        beat++;
      end
      @(negedge clk); n++;
    end
    s_data_valid = 1'b0; s_data_last = 1'b0; axi.wready = 1'b0; s_addr_reset = 1'b0;
    check({tag, " beats"}, beat, int'(v.len) + 1);
    check({tag, " wdata_errs"}, data_err, 0);
    check({tag, " wlast_errs"}, last_err, 0);

    n = 0;
    while (n < TIMEOUT) begin
      axi.bvalid = v.stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      axi.bresp  = v.resp;
      #1;
      if (axi.bvalid && axi.bready) break;
      @(negedge clk); n++;
    end
    @(negedge clk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    #1;
    check({tag, " frame_done"}, frame_done, v.exp_done);
    check({tag, " wr_error"}, wr_error, v.exp_err);
    @(negedge clk);
    check({tag, " done_pulse_end"}, frame_done, 0);
  endtask

  initial begin
    //           rst h  w    len    bad  resp  stl mode addr              done err
    vecs[0]  = '{1, 2, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0000,     1'b0, 1'b0};
    vecs[1]  = '{0, 2, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0400,     1'b1, 1'b0};
    vecs[2]  = '{0, 2, 256, 8'h0f, -1,  2'b00, 1, 0, B1 + 32'h000,      1'b0, 1'b0};
    vecs[3]  = '{0, 2, 256, 8'h3f, -1,  2'b00, 1, 0, B1 + 32'h040,      1'b0, 1'b0};
    vecs[4]  = '{0, 2, 256, 8'h07, -1,  2'b00, 1, 1, B1 + 32'h140,      1'b0, 1'b0};
    vecs[5]  = '{0, 2, 256, 8'h07, -1,  2'b00, 0, 0, B1 + 32'h000,      1'b0, 1'b0};
    vecs[6]  = '{0, 2, 256, 8'h07,  3,  2'b00, 0, 0, B1 + 32'h020,      1'b0, 1'b1};
    vecs[7]  = '{0, 2, 256, 8'h07, -1,  2'b10, 1, 0, B1 + 32'h040,      1'b0, 1'b1};
    vecs[8]  = '{1, 2, 256, 8'hff, -1,  2'b10, 0, 0, 32'h0000_0000,     1'b0, 1'b1};
    vecs[9]  = '{0, 2, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0400,     1'b1, 1'b1};
    vecs[10] = '{1, 2, 256, 8'hff, 100, 2'b00, 0, 0, 32'h0000_0000,     1'b0, 1'b1};
    vecs[11] = '{1, 1, 200, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0000,     1'b1, 1'b0};
    vecs[12] = '{0, 1, 200, 8'h00, -1,  2'b00, 1, 0, B1,                1'b0, 1'b0};
    vecs[13] = '{1, 0, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0000,     1'b0, 1'b0};
    vecs[14] = '{0, 0, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0400,     1'b0, 1'b0};
    vecs[15] = '{0, 0, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0800,     1'b0, 1'b0};
    vecs[16] = '{1, 1, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0000,     1'b1, 1'b0};
    vecs[17] = '{0, 1, 256, 8'hff, -1,  2'b00, 0, 0, B1,                1'b1, 1'b0};
    vecs[18] = '{0, 1, 256, 8'hff, -1,  2'b00, 0, 0, 32'h0000_0000,     1'b1, 1'b0};
    vecs[19] = '{0, 2, 256, 8'h0f, -1,  2'b00, 0, 0, B1 + 32'h000,      1'b0, 1'b0};
    vecs[20] = '{0, 2, 256, 8'h07, -1,  2'b00, 0, 2, B1 + 32'h040,      1'b0, 1'b0};

    frame_height_width = 32'd0;
    apply_reset();
    #1;
    check("reset awvalid", axi.awvalid, 0);
    check("reset wvalid", axi.wvalid, 0);
    check("reset bready", axi.bready, 0);
    check("reset s_burst_ready", s_burst_ready, 0);
    check("reset s_data_ready", s_data_ready, 0);
    check("reset awaddr", axi.awaddr, 32'h0000_0000);
    check("reset awlen", {24'd0, axi.awlen}, 0);
    check("reset frame_done", frame_done, 0);
    check("reset wr_error", wr_error, 0);
    check("awsize", {29'd0, axi.awsize}, 32'd2);
    check("awburst", {30'd0, axi.awburst}, 32'd1);
    check("wstrb", {28'd0, axi.wstrb}, 32'hf);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].do_rst) apply_reset();
      run_burst($sformatf("v%0d", i), vecs[i]);
    end

    // enable is low after vector 20: descriptors must be refused
    s_burst_valid = 1'b1; s_burst_len = 8'h03;
    repeat (4) @(negedge clk);
    #1;
    check("disabled s_burst_ready", s_burst_ready, 0);
    check("disabled awvalid", axi.awvalid, 0);
    s_burst_valid = 1'b0;
    @(negedge clk);

    // the mid-burst enable drop restarted the offset at the base
    hv = '{0, 2, 256, 8'h07, -1, 2'b00, 0, 0, B1 + 32'h000, 1'b0, 1'b0};
    run_burst("after_en_drop", hv);
    hv = '{0, 2, 256, 8'h0f, -1, 2'b00, 1, 0, B1 + 32'h020, 1'b0, 1'b0};
    run_burst("pre_idle_reset", hv);

    // s_addr_reset in IDLE takes effect at once
    s_addr_reset = 1'b1;
    @(negedge clk);
    s_addr_reset = 1'b0;
    hv = '{0, 2, 256, 8'h07, -1, 2'b00, 0, 0, B1 + 32'h000, 1'b0, 1'b0};
    run_burst("after_idle_reset", hv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
